// File: rtl/riscv_pkg.sv
// Core-wide shared definitions.
// Load width/extension select codes used by decode and writeback.
package riscv_pkg;

    localparam int XLEN = 32;

    // bit0 = byte, bit1 = halfword, bit2 = unsigned
    localparam logic [2:0] WIDTH_WORD   = 3'b000;
    localparam logic [2:0] WIDTH_HALF_S = 3'b010;
    localparam logic [2:0] WIDTH_HALF_U = 3'b110;
    localparam logic [2:0] WIDTH_BYTE_S = 3'b001;
    localparam logic [2:0] WIDTH_BYTE_U = 3'b101;

endpackage

// File: rtl/extend_unit.sv
// Sign- or zero-extends an N-bit value to the full data width.
// Used for the byte and halfword load paths.
module extend_unit
    import riscv_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    value,
    input  logic            isSigned,
    output logic [XLEN-1:0] extended
);

    logic fillBit;

    assign fillBit  = isSigned & value[N-1];
    assign extended = {{(XLEN-N){fillBit}}, value};

endmodule

// File: rtl/load_reduce.sv
// Load-result width reducer for LW/LH/LHU/LB/LBU.
// Combinational result plus a registered copy for writeback.
module load_reduce
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] BaseResult,
    input  logic [2:0]  WidthSrc,
    output logic [31:0] Result,
    output logic [31:0] ResultQ
);

    logic        isSigned;
    logic [31:0] byteExt;
    logic [31:0] halfExt;

    assign isSigned = ~WidthSrc[2];

    extend_unit #(.N(8)) byteExtend (
        .value    (BaseResult[7:0]),
        .isSigned (isSigned),
        .extended (byteExt)
    );

    extend_unit #(.N(16)) halfExtend (
        .value    (BaseResult[15:0]),
        .isSigned (isSigned),
        .extended (halfExt)
    );

    // Unused codes resolve to zero so nothing downstream sees X.
    always_comb begin
        Result = '0;
        unique case (1'b1)
            (WidthSrc == WIDTH_WORD):   Result = BaseResult;
            (WidthSrc == WIDTH_HALF_S): Result = halfExt;
            (WidthSrc == WIDTH_HALF_U): Result = halfExt;
            (WidthSrc == WIDTH_BYTE_S): Result = byteExt;
            (WidthSrc == WIDTH_BYTE_U): Result = byteExt;
            default:                    Result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ResultQ <= '0;
        end else begin
            ResultQ <= Result;
        end
    end

endmodule

// File: tb/tb_load_reduce.sv
// Directed self-checking bench for load_reduce.
// Combinational reduce, register path and async reset.
module tb_load_reduce;

    logic        clk;
    logic        reset;
    logic [31:0] BaseResult;
    logic [2:0]  WidthSrc;
    logic [31:0] Result;
    logic [31:0] ResultQ;

    int cmpCount = 0;
    int errCount = 0;

    load_reduce dut (
        .clk        (clk),
        .reset      (reset),
        .BaseResult (BaseResult),
        .WidthSrc   (WidthSrc),
        .Result     (Result),
        .ResultQ    (ResultQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refReduce(input logic [31:0] b,
                                              input logic [2:0] w);
        case (w)
            3'b000:  return b;
            3'b010:  return {{16{b[15]}}, b[15:0]};
            3'b110:  return {16'h0000, b[15:0]};
            3'b001:  return {{24{b[7]}}, b[7:0]};
            3'b101:  return {24'h000000, b[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        reset      = 1'b0;
        BaseResult = 32'h0;
        WidthSrc   = 3'b000;
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0) begin
            errCount++;
            $display("FAIL reset_q got %h want %h", ResultQ, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_word();
        BaseResult = 32'hDEADBEEF;
        WidthSrc   = 3'b000;
        #1;
        cmpCount++;
        if (Result !== 32'hDEADBEEF) begin
            errCount++;
            $display("FAIL word got %h want %h", Result, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte();
        logic [31:0] b[3] = '{32'h1234_80FF, 32'h1234_80FF, 32'hFFFF_FF7F};
        logic [2:0]  w[3] = '{3'b001, 3'b101, 3'b001};
        logic [31:0] e[3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_007F};
        for (int i = 0; i < 3; i++) begin
            BaseResult = b[i];
            WidthSrc   = w[i];
            #1;
            cmpCount++;
            if (Result !== e[i]) begin
                errCount++;
                $display("FAIL byte[%0d] got %h want %h", i, Result, e[i]);
            end
        end
    endtask

    task automatic test_half();
        logic [31:0] b[3] = '{32'hABCD_8001, 32'hABCD_8001, 32'h0000_7FFF};
        logic [2:0]  w[3] = '{3'b010, 3'b110, 3'b010};
        logic [31:0] e[3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF};
        for (int i = 0; i < 3; i++) begin
            BaseResult = b[i];
            WidthSrc   = w[i];
            #1;
            cmpCount++;
            if (Result !== e[i]) begin
                errCount++;
                $display("FAIL half[%0d] got %h want %h", i, Result, e[i]);
            end
        end
    endtask

    task automatic test_unused();
        logic [2:0] w[3] = '{3'b011, 3'b100, 3'b111};
        BaseResult = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            WidthSrc = w[i];
            #1;
            cmpCount++;
            if (Result !== 32'h0) begin
                errCount++;
                $display("FAIL unused[%b] got %h want %h", w[i], Result, 32'h0);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        WidthSrc   = 3'b101;
        BaseResult = 32'h0000_00A5;
        @(posedge clk);
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0000_00A5) begin
            errCount++;
            $display("FAIL reg_load got %h want %h", ResultQ, 32'h0000_00A5);
        end
        WidthSrc   = 3'b010;
        BaseResult = 32'h0000_F00D;
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0000_00A5) begin
            errCount++;
            $display("FAIL reg_hold got %h want %h", ResultQ, 32'h0000_00A5);
        end
        cmpCount++;
        if (Result !== 32'hFFFF_F00D) begin
            errCount++;
            $display("FAIL reg_comb got %h want %h", Result, 32'hFFFF_F00D);
        end
        @(posedge clk);
        #1;
        cmpCount++;
        if (ResultQ !== 32'hFFFF_F00D) begin
            errCount++;
            $display("FAIL reg_next got %h want %h", ResultQ, 32'hFFFF_F00D);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0) begin
            errCount++;
            $display("FAIL arst_q got %h want %h", ResultQ, 32'h0);
        end
        cmpCount++;
        if (Result !== 32'hFFFF_F00D) begin
            errCount++;
            $display("FAIL arst_comb got %h want %h", Result, 32'hFFFF_F00D);
        end
        WidthSrc   = 3'b001;
        BaseResult = 32'h0000_0080;
        #1;
        cmpCount++;
        if (Result !== 32'hFFFF_FF80) begin
            errCount++;
            $display("FAIL arst_track got %h want %h", Result, 32'hFFFF_FF80);
        end
        @(posedge clk);
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0) begin
            errCount++;
            $display("FAIL arst_held got %h want %h", ResultQ, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmpCount++;
        if (ResultQ !== 32'h0) begin
            errCount++;
            $display("FAIL arst_rel got %h want %h", ResultQ, 32'h0);
        end
        @(posedge clk);
        #1;
        cmpCount++;
        if (ResultQ !== 32'hFFFF_FF80) begin
            errCount++;
            $display("FAIL arst_first got %h want %h", ResultQ, 32'hFFFF_FF80);
        end
    endtask

    task automatic test_sweep();
        logic [2:0]  codes[5] = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b101};
        logic [31:0] exp;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            BaseResult = $urandom;
            WidthSrc   = codes[i % 5];
            exp        = refReduce(BaseResult, WidthSrc);
            #1;
            cmpCount++;
            if (Result !== exp) begin
                errCount++;
                $display("FAIL sweep[%0d] b=%h w=%b got %h want %h",
                         i, BaseResult, WidthSrc, Result, exp);
            end
            @(posedge clk);
            #1;
            cmpCount++;
            if (ResultQ !== exp) begin
                errCount++;
                $display("FAIL sweep_q[%0d] got %h want %h", i, ResultQ, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_unused();
        test_register();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/load_reduce.md
# load_reduce

Load-result width reducer in the memory/writeback path of the pipelined RV32I core. It takes the 32-bit word returned for a load and produces the architecturally correct value for LW, LH, LHU, LB or LBU. It selects the low halfword or low byte and sign- or zero-extends it to 32 bits. Primary output is combinational; a registered copy is also provided for the writeback stage.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: single clock; drives only the registered output.
- `reset` input 1: asynchronous, active-low reset; clears the registered output.
- `BaseResult` input 32: raw loaded word, already aligned so the wanted byte/halfword sits in the low bits.
- `WidthSrc` input 3: width/extension select.
- `Result` output 32: combinational reduced value.
- `ResultQ` output 32: `Result` registered on `clk` rising edge.

## Operation
WidthSrc encoding: bit0 = byte, bit1 = halfword, bit2 = unsigned.
- `000` word: `Result = BaseResult`.
- `010` halfword signed: `{{16{BaseResult[15]}}, BaseResult[15:0]}`.
- `110` halfword unsigned: `{16'b0, BaseResult[15:0]}`.
- `001` byte signed: `{{24{BaseResult[7]}}, BaseResult[7:0]}`.
- `101` byte unsigned: `{24'b0, BaseResult[7:0]}`.
- Unused codes (`011`, `100`, `111`): `Result = 32'h0000_0000`. Never X.
- Upper bits of `BaseResult` beyond the selected width are ignored for byte and halfword codes.
- No byte-lane shifting inside this block; alignment is upstream's job.

## Timing
- `Result`: purely combinational, zero cycle latency, settles within the same cycle as its inputs. Must not depend on `clk` or `reset`.
- `ResultQ`: one-cycle latency. It holds the value `Result` had at the previous rising edge of `clk`.
- `reset` low: `ResultQ` = 0 immediately, independent of `clk`.
- `reset` low has no effect on `Result`.
- Reset release: the first rising edge with `reset` high loads `ResultQ`.
- There is no enable or stall; `ResultQ` updates every cycle.

## Structure
- Shared package (core-wide `riscv_pkg`) holds WidthSrc localparams: `WIDTH_WORD=3'b000`, `WIDTH_HALF_S=3'b010`, `WIDTH_HALF_U=3'b110`, `WIDTH_BYTE_S=3'b001`, `WIDTH_BYTE_U=3'b101`. The decode unit uses the same constants.
- One natural sub-module: `extend_unit`.
  - Inputs: N-bit value and a signed flag.
  - Output: 32-bit value, sign- or zero-extended.
  - Instantiated for the byte path and the halfword path.
- Top: select mux plus one output register.

## Test plan
- `BaseResult=32'hDEADBEEF`, `WidthSrc=000` -> `Result=32'hDEADBEEF`.
- `BaseResult=32'h1234_80FF`, `WidthSrc=001` -> `32'hFFFF_FFFF`; `WidthSrc=101` -> `32'h0000_00FF`; `BaseResult=32'hFFFF_FF7F`, `WidthSrc=001` -> `32'h0000_007F`.
- `BaseResult=32'hABCD_8001`, `WidthSrc=010` -> `32'hFFFF_8001`; `WidthSrc=110` -> `32'h0000_8001`; `BaseResult=32'h0000_7FFF`, `WidthSrc=010` -> `32'h0000_7FFF`.
- Unused codes `011`/`100`/`111` with `BaseResult=32'hFFFF_FFFF` -> `Result=0`.
- Register path: set `WidthSrc=101`, `BaseResult=32'h0000_00A5`. After one `clk` edge, `ResultQ=32'h0000_00A5`. Change inputs; `ResultQ` changes only at the next edge.
- Reset: drive `reset` low mid-cycle with `ResultQ` nonzero -> `ResultQ=0` immediately while `Result` still tracks its inputs. After release, `ResultQ` follows `Result` at the next edge.
- Sweep file-driven vectors over all five legal codes with random `BaseResult`. Compare `Result` 1 ns after each input change.
